// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, ALUOp
// encodings, R-type opcode constants and the registered beat layout.
package alu_issue_stage_pkg;

  localparam int unsigned BEAT_DATA_W = 64;
  localparam int unsigned BEAT_RD_W   = 5;
  localparam int unsigned BEAT_OPC_W  = 11;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // ALUOp from main control
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,  // load/store address add
    ALUOP_BRANCH = 2'b01,  // branch compare subtract
    ALUOP_RTYPE  = 2'b10,  // operation taken from opcode field
    ALUOP_RSVD   = 2'b11
  } alu_op_e;

  // R-type opcode field values (instruction[31:21])
  localparam logic [BEAT_OPC_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [BEAT_OPC_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [BEAT_OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [BEAT_OPC_W-1:0] OPC_ORR = 11'b10101010000;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data1;
    logic [BEAT_DATA_W-1:0] data2;
    logic [3:0]             ctrl;
    logic [BEAT_RD_W-1:0]   rd;
    logic                   illegal;
  } beat_t;

endpackage

// File: rtl/alu_issue_stage_ctrl.sv
// alu_ctrl_decode: combinational ALUOp + opcode -> 4-bit ALU control.
// Ports:
//   alu_op  in  2      ALUOp from main control
//   opcode  in  OPC_W  R-type opcode field
//   ctrl    out 4      ALU control code
//   illegal out 1      unknown R-type opcode or reserved ALUOp
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned OPC_W = BEAT_OPC_W
) (
  input  logic [1:0]       alu_op,
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       ctrl,
  output logic             illegal
);

  always_comb begin
    ctrl    = ALU_AND;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALUOP_MEM:    ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: ctrl = ALU_ADD;
          OPC_SUB: ctrl = ALU_SUB;
          OPC_AND: ctrl = ALU_AND;
          OPC_ORR: ctrl = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register stage feeding the 64-bit ALU.
// Registers operand 1, the muxed operand 2, the decoded ALU control and rd.
// Valid/ready on both sides; a one-entry skid buffer lets in_ready be a flop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of main and skid entries
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_rs1_data, in_rs2_data, in_imm, in_alu_src, in_alu_op, in_opcode, in_rd
//                     decoded beat fields
//   out_valid/out_ready downstream handshake
//   input_data_1, input_data_2, alu_control, out_rd, out_illegal
//                     registered ALU inputs, held stable during a stall
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = BEAT_DATA_W,
  parameter int unsigned REG_ADDR_W = BEAT_RD_W,
  parameter int unsigned OPC_W      = BEAT_OPC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_rs1_data,
  input  logic [DATA_W-1:0]     in_rs2_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_alu_src,
  input  logic [1:0]            in_alu_op,
  input  logic [OPC_W-1:0]      in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     input_data_1,
  output logic [DATA_W-1:0]     input_data_2,
  output logic [3:0]            alu_control,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_illegal
);

  beat_t in_beat;
  beat_t main_q;
  beat_t skid_q;
  logic  main_valid_q;
  logic  skid_valid_q;
  logic  in_ready_q;
  logic  dec_illegal;
  logic  [3:0] dec_ctrl;

  logic accept;
  logic main_open;

  alu_ctrl_decode #(.OPC_W(OPC_W)) u_ctrl_decode (
    .alu_op  (in_alu_op),
    .opcode  (in_opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_comb begin
    in_beat.data1   = in_rs1_data;
    in_beat.data2   = in_alu_src ? in_imm : in_rs2_data;
    in_beat.ctrl    = dec_ctrl;
    in_beat.rd      = in_rd;
    in_beat.illegal = dec_illegal;
  end

  assign accept    = in_valid & in_ready_q;
  // Main register may take a new beat when empty or being consumed this cycle
  assign main_open = ~main_valid_q | out_ready;

  // in_ready is always the complement of skid occupancy, so a full skid
  // blocks acceptance and only main_open can move it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (main_open) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else if (accept) begin
        main_q       <= in_beat;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign input_data_1 = main_q.data1;
  assign input_data_2 = main_q.data2;
  assign alu_control  = main_q.ctrl;
  assign out_rd       = main_q.rd;
  assign out_illegal  = main_q.illegal;

endmodule
